reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk in 1, clock; resetn in 1, asynchronous active-low reset.
REQ-002 SHALL have: flush in 1 (external pipeline flush); map_to_rob_bus1/map_to_rob_bus2 in rob_entry_t (dispatch slots; slot2 valid only if slot1 valid).
REQ-003 SHALL have: rob_allowin out 1 (>=2 free entries); rob_tail_o out 4 (next allocation index); rob_head_o out 4.
REQ-004 SHALL have 3 writeback ports k=0..2: wb_valid[k] in 1, wb_rob_idx[k] in 4, wb_exception[k] in exception_t.
REQ-005 SHALL have commit ports j=1,2: commit_valid_j out 1, commit_entry_j out rob_entry_t.
REQ-006 SHALL have: commit_exception out 1, commit_eret out 1, commit_ex_pc out virt_t, commit_ex_info out exception_t.

Function
REQ-007 Storage SHALL be 16 rob_entry_t entries, circular, head/tail 4-bit wrapping modulo 16, count 5-bit (0..16).
REQ-008 A dispatch slot SHALL allocate only when its state != Inst_Invalid and rob_allowin=1; slot1 at tail, slot2 at tail+1; tail advances by number allocated at the edge.
REQ-009 rob_allowin SHALL be combinational: (16 - count) >= 2; dispatch with rob_allowin=0 SHALL be ignored.
REQ-010 Entries dispatched with state Inst_Complete (decode exception) SHALL be stored as complete.
REQ-011 wb_valid[k] SHALL set entry wb_rob_idx[k] to Inst_Complete and OR in wb_exception[k] at the edge; writeback to an entry in Inst_Invalid state SHALL be ignored.
REQ-012 Commit SHALL be combinational from registered state: an entry completed at edge N is eligible during cycle N+1; head advances at end of that cycle.
REQ-013 commit_valid_1 SHALL assert when count>0 and head entry is Inst_Complete with exception.ex=0 and is_eret=0.
REQ-014 commit_valid_2 SHALL assert only if commit_valid_1, entry head+1 is Inst_Complete, count>=2, no exception, not eret, not privileged, head entry not privileged, and not both entries stores.
REQ-015 Head entry complete with exception.ex=1: commit_exception=1, commit_ex_pc/commit_ex_info from entry, commit_valid_1=0, internal flush at the edge.
REQ-016 Head entry complete with is_eret=1: commit_valid_1=1, commit_eret=1, commit_valid_2=0, internal flush at the edge.
REQ-017 Flush (external or internal) SHALL clear all states to Inst_Invalid, head=tail=count=0 at the edge, overriding same-cycle dispatch and writeback.
REQ-018 Simultaneous dispatch and commit: count_next = count + allocated - committed; full and commit same cycle SHALL still honour REQ-009 on current count.
REQ-019 Committed entries SHALL be set to Inst_Invalid at the edge.
REQ-020 Writeback and commit of the same index in one cycle: commit uses registered state; writeback to a just-committed (freed) index is ignored next cycle per REQ-011.
REQ-021 commit_entry_j SHALL reflect stored entry contents even when commit_valid_j=0.

Reset
REQ-022 resetn=0 SHALL asynchronously clear head, tail, count to 0 and all entry states to Inst_Invalid.
REQ-023 During/after reset: rob_allowin=1, rob_tail_o=0, rob_head_o=0, all commit outputs 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries; no commit pulses in the cycle after release.

Structure
REQ-025 rob_entry_t, inst_state_t (Inst_Invalid/Inst_Wait/Inst_Complete), exception_t, virt_t and constant ROB_DEPTH=16 SHALL live in the shared cpu package header.
REQ-026 Commit-eligibility logic (REQ-013..016) SHALL be a combinational sub-module rob_commit_sel; storage and pointers stay in reorder_buffer.

Verification
REQ-027 Reset, dispatch 2 valid entries pc 0x100/0x104 -> rob_tail_o 0->2, count 2, no commit until writeback.
REQ-028 wb idx1 then idx0 in later cycle -> nothing commits after idx1 wb; cycle after idx0 wb both commit same cycle, head=2.
REQ-029 Fill to count 15 -> rob_allowin=0, dispatch dropped, tail unchanged; one commit -> count 14, rob_allowin=1.
REQ-030 Head at 15, dispatch 2, commit 2 -> tail wraps 15->1, entries at 15 and 0 commit in order.
REQ-031 wb exception.ex=1 on head pc 0x200 with 3 younger entries -> commit_exception=1, commit_ex_pc=0x200, next cycle count=0, younger entries never commit.
REQ-032 External flush same cycle as dispatch of 2 and 3 writebacks -> next cycle head=tail=count=0, all entries invalid.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared CPU types for the reorder buffer: entry layout, instruction state,
// exception record and virtual address type.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;

  typedef logic [31:0] virt_t;

  typedef enum logic [1:0] {
    Inst_Invalid  = 2'd0,
    Inst_Wait     = 2'd1,
    Inst_Complete = 2'd2
  } inst_state_t;

  typedef struct packed {
    logic       ex;
    logic [5:0] ecode;
  } exception_t;

  typedef struct packed {
    inst_state_t state;
    virt_t       pc;
    exception_t  exception;
    logic        is_eret;
    logic        is_priv;
    logic        is_store;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational commit selection: decides which of the two oldest entries
// retire this cycle and whether the head raises an exception or eret flush.
module rob_commit_sel
  import reorder_buffer_pkg::*;
(
  input  logic [4:0]  count,
  input  rob_entry_t  head_entry,
  input  inst_state_t next_state,
  input  logic        next_ex,
  input  logic        next_eret,
  input  logic        next_priv,
  input  logic        next_store,
  output logic        commit_valid_1,
  output logic        commit_valid_2,
  output logic        commit_exception,
  output logic        commit_eret,
  output virt_t       commit_ex_pc,
  output exception_t  commit_ex_info,
  output logic        flush_req
);

  logic head_done;
  logic pair_ok;

  assign head_done        = (count != 5'd0) && (head_entry.state == Inst_Complete);
  assign commit_exception = head_done && head_entry.exception.ex;
  assign commit_valid_1   = head_done && !head_entry.exception.ex;
  assign commit_eret      = commit_valid_1 && head_entry.is_eret;

  // Dual retire only for plain instructions; at most one store per cycle.
  assign pair_ok = (count >= 5'd2) && (next_state == Inst_Complete) &&
                   !next_ex && !next_eret && !next_priv &&
                   !head_entry.is_eret && !head_entry.is_priv &&
                   !(head_entry.is_store && next_store);

  assign commit_valid_2 = commit_valid_1 && pair_ok;

  assign commit_ex_pc   = commit_exception ? head_entry.pc : '0;
  assign commit_ex_info = commit_exception ? head_entry.exception : '0;
  assign flush_req      = commit_exception || commit_eret;

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: dual dispatch, three writeback ports,
// in-order dual commit with exception/eret flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  rob_entry_t       map_to_rob_bus1,
  input  rob_entry_t       map_to_rob_bus2,
  output logic             rob_allowin,
  output logic [3:0]       rob_tail_o,
  output logic [3:0]       rob_head_o,
  input  logic [2:0]       wb_valid,
  input  logic [2:0][3:0]  wb_rob_idx,
  input  exception_t [2:0] wb_exception,
  output logic             commit_valid_1,
  output rob_entry_t       commit_entry_1,
  output logic             commit_valid_2,
  output rob_entry_t       commit_entry_2,
  output logic             commit_exception,
  output logic             commit_eret,
  output virt_t            commit_ex_pc,
  output exception_t       commit_ex_info
);

  rob_entry_t entries     [ROB_DEPTH];
  rob_entry_t entries_nxt [ROB_DEPTH];

  logic [3:0] head, tail, head_p1, tail_p1;
  logic [4:0] count;
  logic       alloc_1, alloc_2;
  logic [1:0] n_alloc, n_commit;
  logic       flush_int, flush_all;

  assign head_p1     = head + 4'd1;
  assign tail_p1     = tail + 4'd1;
  assign rob_allowin = (count <= 5'(ROB_DEPTH - 2));
  assign alloc_1     = rob_allowin && (map_to_rob_bus1.state != Inst_Invalid);
  assign alloc_2     = alloc_1 && (map_to_rob_bus2.state != Inst_Invalid);
  assign n_alloc     = {1'b0, alloc_1} + {1'b0, alloc_2};
  assign n_commit    = {1'b0, commit_valid_1} + {1'b0, commit_valid_2};
  assign flush_all   = flush || flush_int;

  assign rob_tail_o     = tail;
  assign rob_head_o     = head;
  assign commit_entry_1 = entries[head];
  assign commit_entry_2 = entries[head_p1];

  rob_commit_sel u_commit_sel (
    .count            (count),
    .head_entry       (entries[head]),
    .next_state       (entries[head_p1].state),
    .next_ex          (entries[head_p1].exception.ex),
    .next_eret        (entries[head_p1].is_eret),
    .next_priv        (entries[head_p1].is_priv),
    .next_store       (entries[head_p1].is_store),
    .commit_valid_1   (commit_valid_1),
    .commit_valid_2   (commit_valid_2),
    .commit_exception (commit_exception),
    .commit_eret      (commit_eret),
    .commit_ex_pc     (commit_ex_pc),
    .commit_ex_info   (commit_ex_info),
    .flush_req        (flush_int)
  );

  // Writeback looks at registered state so freed slots ignore late results;
  // exceptions accumulate when several ports hit one entry.
  always_comb begin
    entries_nxt = entries;
    for (int k = 0; k < 3; k++) begin
      if (wb_valid[k] && (entries[wb_rob_idx[k]].state != Inst_Invalid)) begin
        entries_nxt[wb_rob_idx[k]].state     = Inst_Complete;
        entries_nxt[wb_rob_idx[k]].exception = entries_nxt[wb_rob_idx[k]].exception | wb_exception[k];
      end
    end
    if (commit_valid_1) entries_nxt[head].state    = Inst_Invalid;
    if (commit_valid_2) entries_nxt[head_p1].state = Inst_Invalid;
    if (alloc_1) begin
      entries_nxt[tail] = map_to_rob_bus1;
      entries_nxt[tail].state = (map_to_rob_bus1.state == Inst_Complete) ? Inst_Complete : Inst_Wait;
    end
    if (alloc_2) begin
      entries_nxt[tail_p1] = map_to_rob_bus2;
      entries_nxt[tail_p1].state = (map_to_rob_bus2.state == Inst_Complete) ? Inst_Complete : Inst_Wait;
    end
    if (flush_all) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_nxt[i].state = Inst_Invalid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      entries <= entries_nxt;
      if (flush_all) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + {2'b00, n_commit};
        tail  <= tail + {2'b00, n_alloc};
        count <= count + {3'b000, n_alloc} - {3'b000, n_commit};
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush;
  rob_entry_t       bus1, bus2;
  logic             rob_allowin;
  logic [3:0]       rob_tail_o, rob_head_o;
  logic [2:0]       wb_valid;
  logic [2:0][3:0]  wb_rob_idx;
  exception_t [2:0] wb_exception;
  logic             commit_valid_1, commit_valid_2, commit_exception, commit_eret;
  rob_entry_t       commit_entry_1, commit_entry_2;
  virt_t            commit_ex_pc;
  exception_t       commit_ex_info;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .map_to_rob_bus1(bus1), .map_to_rob_bus2(bus2),
    .rob_allowin(rob_allowin), .rob_tail_o(rob_tail_o), .rob_head_o(rob_head_o),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_exception(wb_exception),
    .commit_valid_1(commit_valid_1), .commit_entry_1(commit_entry_1),
    .commit_valid_2(commit_valid_2), .commit_entry_2(commit_entry_2),
    .commit_exception(commit_exception), .commit_eret(commit_eret),
    .commit_ex_pc(commit_ex_pc), .commit_ex_info(commit_ex_info)
  );

  // Reference model: in-flight instructions in program order, oldest first.
  typedef struct {
    int         idx;
    virt_t      pc;
    bit         done;
    exception_t exc;
    bit         eret, priv, store;
  } mrec_t;

  mrec_t q[$];
  int    m_head, m_tail;
  int    n_cmp, n_bad;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rob_entry_t mk(input virt_t pc, input inst_state_t st, input bit store);
    rob_entry_t e;
    e = '0;
    e.pc = pc;
    e.state = st;
    e.is_store = store;
    return e;
  endfunction

  function automatic void expect_commit(output bit v1, output bit v2, output bit ex, output bit er);
    v1 = 0; v2 = 0; ex = 0; er = 0;
    if (q.size() > 0 && q[0].done) begin
      if (q[0].exc.ex) ex = 1;
      else begin
        v1 = 1;
        er = q[0].eret;
        if (!q[0].eret && !q[0].priv && q.size() >= 2 && q[1].done && !q[1].exc.ex &&
            !q[1].eret && !q[1].priv && !(q[0].store && q[1].store))
          v2 = 1;
      end
    end
  endfunction

  task automatic check_outputs();
    bit v1, v2, ex, er;
    expect_commit(v1, v2, ex, er);
    cmp("allowin", rob_allowin, (q.size() <= 14));
    cmp("tail", rob_tail_o, m_tail);
    cmp("head", rob_head_o, m_head);
    cmp("commit_valid_1", commit_valid_1, v1);
    cmp("commit_valid_2", commit_valid_2, v2);
    cmp("commit_exception", commit_exception, ex);
    cmp("commit_eret", commit_eret, er);
    if (v1) cmp("commit_pc_1", commit_entry_1.pc, q[0].pc);
    if (v2) cmp("commit_pc_2", commit_entry_2.pc, q[1].pc);
    if (ex) begin
      cmp("ex_pc", commit_ex_pc, q[0].pc);
      cmp("ex_info", commit_ex_info, q[0].exc);
    end
  endtask

  function automatic void push(input rob_entry_t b);
    mrec_t r;
    r.idx = m_tail; r.pc = b.pc; r.done = (b.state == Inst_Complete);
    r.exc = b.exception; r.eret = b.is_eret; r.priv = b.is_priv; r.store = b.is_store;
    q.push_back(r);
    m_tail = (m_tail + 1) % 16;
  endfunction

  task automatic model_step();
    bit v1, v2, ex, er, room;
    expect_commit(v1, v2, ex, er);
    room = (q.size() <= 14);
    if (flush || ex || er) begin
      q.delete(); m_head = 0; m_tail = 0;
      return;
    end
    if (v1) begin void'(q.pop_front()); m_head = (m_head + 1) % 16; end
    if (v2) begin void'(q.pop_front()); m_head = (m_head + 1) % 16; end
    for (int k = 0; k < 3; k++)
      if (wb_valid[k])
        foreach (q[i])
          if (q[i].idx == int'(wb_rob_idx[k])) begin
            q[i].done = 1;
            q[i].exc  = q[i].exc | wb_exception[k];
          end
    if (room && bus1.state != Inst_Invalid) begin
      push(bus1);
      if (bus2.state != Inst_Invalid) push(bus2);
    end
  endtask

  task automatic idle();
    flush = 0; bus1 = '0; bus2 = '0;
    wb_valid = '0; wb_rob_idx = '0; wb_exception = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    idle();
  endtask

  function automatic rob_entry_t rand_entry(input bit valid);
    rob_entry_t e;
    e = '0;
    e.pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    e.state = !valid ? Inst_Invalid : (($urandom_range(0, 7) == 0) ? Inst_Complete : Inst_Wait);
    if (e.state == Inst_Complete && $urandom_range(0, 3) == 0) begin
      e.exception.ex = 1'b1;
      e.exception.ecode = 6'($urandom_range(0, 63));
    end
    e.is_eret  = ($urandom_range(0, 39) == 0);
    e.is_priv  = ($urandom_range(0, 9) == 0);
    e.is_store = ($urandom_range(0, 2) == 0);
    return e;
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; m_head = 0; m_tail = 0;
    idle();
    repeat (2) @(negedge clk);
    cmp("rst_allowin", rob_allowin, 1);
    cmp("rst_tail", rob_tail_o, 0);
    cmp("rst_head", rob_head_o, 0);
    cmp("rst_cv1", commit_valid_1, 0);
    cmp("rst_cexc", commit_exception, 0);
    resetn = 1;
    @(negedge clk);
    check_outputs();

    // two dispatches, nothing commits before writeback
    bus1 = mk(32'h100, Inst_Wait, 0); bus2 = mk(32'h104, Inst_Wait, 0);
    tick();
    cmp("d_tail2", rob_tail_o, 2);
    cmp("d_head0", rob_head_o, 0);
    cmp("d_nocommit", commit_valid_1, 0);

    // younger completes first: no commit until the head completes
    wb_valid = 3'b001; wb_rob_idx[0] = 4'd1;
    tick();
    cmp("ooo_wait", commit_valid_1, 0);
    wb_valid = 3'b001; wb_rob_idx[0] = 4'd0;
    tick();
    cmp("ooo_cv1", commit_valid_1, 1);
    cmp("ooo_cv2", commit_valid_2, 1);
    cmp("ooo_pc1", commit_entry_1.pc, 32'h100);
    cmp("ooo_pc2", commit_entry_2.pc, 32'h104);
    tick();
    cmp("ooo_head2", rob_head_o, 2);

    // fill to 15, dispatch refused, one commit reopens
    for (int i = 0; i < 7; i++) begin
      bus1 = mk(32'h400 + 8 * i, Inst_Wait, 0); bus2 = mk(32'h404 + 8 * i, Inst_Wait, 0);
      tick();
    end
    bus1 = mk(32'h440, Inst_Wait, 0);
    tick();
    cmp("full_allowin0", rob_allowin, 0);
    cmp("full_tail", rob_tail_o, 1);
    bus1 = mk(32'h500, Inst_Wait, 0); bus2 = mk(32'h504, Inst_Wait, 0);
    tick();
    cmp("full_drop_tail", rob_tail_o, 1);
    wb_valid = 3'b001; wb_rob_idx[0] = 4'd2;
    tick();
    cmp("full_cv1", commit_valid_1, 1);
    tick();
    cmp("full_allowin1", rob_allowin, 1);

    // external flush overrides dispatch and writebacks
    flush = 1;
    bus1 = mk(32'h600, Inst_Wait, 0); bus2 = mk(32'h604, Inst_Wait, 0);
    wb_valid = 3'b111; wb_rob_idx[0] = 4'd3; wb_rob_idx[1] = 4'd4; wb_rob_idx[2] = 4'd5;
    tick();
    cmp("fl_head", rob_head_o, 0);
    cmp("fl_tail", rob_tail_o, 0);
    cmp("fl_allowin", rob_allowin, 1);
    wb_valid = 3'b001; wb_rob_idx[0] = 4'd0;
    tick();
    cmp("fl_nocommit", commit_valid_1, 0);

    // walk head to 15 with decode-complete entries, then wrap
    for (int i = 0; i < 7; i++) begin
      bus1 = mk(32'h700 + 8 * i, Inst_Complete, 0); bus2 = mk(32'h704 + 8 * i, Inst_Complete, 0);
      tick();
    end
    bus1 = mk(32'h740, Inst_Complete, 0);
    tick();
    repeat (3) tick();
    cmp("wrap_head15", rob_head_o, 15);
    bus1 = mk(32'h300, Inst_Wait, 0); bus2 = mk(32'h304, Inst_Wait, 0);
    tick();
    cmp("wrap_tail1", rob_tail_o, 1);
    wb_valid = 3'b011; wb_rob_idx[0] = 4'd15; wb_rob_idx[1] = 4'd0;
    tick();
    cmp("wrap_cv1", commit_valid_1, 1);
    cmp("wrap_cv2", commit_valid_2, 1);
    cmp("wrap_pc1", commit_entry_1.pc, 32'h300);
    cmp("wrap_pc2", commit_entry_2.pc, 32'h304);
    tick();
    cmp("wrap_head1", rob_head_o, 1);

    // exception at head flushes younger entries
    bus1 = mk(32'h200, Inst_Wait, 0); bus2 = mk(32'h204, Inst_Wait, 0);
    tick();
    bus1 = mk(32'h208, Inst_Wait, 0); bus2 = mk(32'h20c, Inst_Wait, 0);
    tick();
    wb_valid = 3'b111; wb_rob_idx[0] = 4'd1; wb_rob_idx[1] = 4'd2; wb_rob_idx[2] = 4'd3;
    wb_exception[0].ex = 1'b1; wb_exception[0].ecode = 6'd5;
    tick();
    cmp("exc_flag", commit_exception, 1);
    cmp("exc_pc", commit_ex_pc, 32'h200);
    cmp("exc_code", commit_ex_info.ecode, 5);
    cmp("exc_cv1", commit_valid_1, 0);
    tick();
    cmp("exc_head0", rob_head_o, 0);
    cmp("exc_tail0", rob_tail_o, 0);
    cmp("exc_allowin", rob_allowin, 1);
    repeat (3) tick();

    // randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 59) == 0);
      bus1 = rand_entry($urandom_range(0, 9) < 6);
      bus2 = rand_entry((bus1.state != Inst_Invalid) && ($urandom_range(0, 1) == 1));
      for (int k = 0; k < 3; k++) begin
        wb_valid[k] = ($urandom_range(0, 2) == 0);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          wb_rob_idx[k] = 4'(q[$urandom_range(0, q.size() - 1)].idx);
        else
          wb_rob_idx[k] = 4'($urandom_range(0, 15));
        wb_exception[k] = '0;
        if ($urandom_range(0, 24) == 0) begin
          wb_exception[k].ex = 1'b1;
          wb_exception[k].ecode = 6'($urandom_range(0, 63));
        end
      end
      tick();
      if (c == 1500) begin
        #2 resetn = 0;
        #1;
        cmp("mid_rst_allowin", rob_allowin, 1);
        cmp("mid_rst_tail", rob_tail_o, 0);
        cmp("mid_rst_head", rob_head_o, 0);
        cmp("mid_rst_cv1", commit_valid_1, 0);
        q.delete(); m_head = 0; m_tail = 0;
        @(negedge clk);
        resetn = 1;
        check_outputs();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
